// File: rtl/uart_frame_tx.sv
// uart_frame_tx - single-word UART transmitter with fractional baud divider.
//
// Sends one frame per accepted request: start bit, 5/6/7/8/16 data bits
// (LSB first), optional parity bit, then 1, 1.5 or 2 stop bits. Each bit lasts
// DIVIDER_VALUE clocks plus one extra clock whenever the 2-bit fractional
// accumulator carries, so DIV_CORRECT adds quarter-clock corrections per bit.
//
// Ports
//   CLK           in   system clock, rising edge
//   RSTN          in   synchronous active-low reset
//   DIVIDER_VALUE in   clocks per bit (values below 2 behave as 2)
//   DIV_CORRECT   in   quarter clocks added per bit
//   PARITY_BIT    in   0 none, 1 odd, 2 even, 3 mark, 4 space (others none)
//   STOP_BIT      in   0 one, 1 one-and-half, 2 two (others one)
//   DATA_BITS     in   5, 6, 7, 8 or 16 (others 8)
//   DATA_IN       in   word to send
//   DATA_SEND     in   send request, honoured only when BUSY is low
//   UART_CTS      in   0 = far end ready
//   UART_TXD      out  serial line, registered, idles high
//   BUSY          out  request would be ignored this cycle
//   DONE          out  one-cycle pulse on the first idle cycle after a frame
module uart_frame_tx (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [23:0] DIVIDER_VALUE,
  input  logic [1:0]  DIV_CORRECT,
  input  logic [7:0]  PARITY_BIT,
  input  logic [7:0]  STOP_BIT,
  input  logic [7:0]  DATA_BITS,
  input  logic [15:0] DATA_IN,
  input  logic        DATA_SEND,
  input  logic        UART_CTS,
  output logic        UART_TXD,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_HALF_STOP
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_txd, w_txd_nxt;
  logic        r_done, w_done_nxt;
  logic [1:0]  r_frac, w_frac_nxt;
  logic [23:0] r_clkcnt, w_clkcnt_nxt;   // clocks left in the current bit, minus one
  logic [4:0]  r_bitcnt, w_bitcnt_nxt;
  logic [15:0] r_shift, w_shift_nxt;
  logic        r_stopcnt, w_stopcnt_nxt; // second stop bit in progress

  // Frame settings captured at accept
  logic [23:0] r_div;
  logic [1:0]  r_corr;
  logic [4:0]  r_nbits;
  logic        r_par_en, r_par_val;
  logic [1:0]  r_stop_mode;

  // Accept-time decode of the raw inputs
  logic [23:0] w_div_in;
  logic [4:0]  w_nbits_in;
  logic [15:0] w_data_act;
  logic        w_par_en_in, w_par_in;
  logic [1:0]  w_stop_in;

  logic        w_accept, w_bit_end, w_next_bit;
  logic [2:0]  w_fsum;
  logic [23:0] w_len_m1;

  always_comb begin
    w_div_in = (DIVIDER_VALUE < 24'd2) ? 24'd2 : DIVIDER_VALUE;
    case (DATA_BITS)
      8'd5:    begin w_nbits_in = 5'd5;  w_data_act = DATA_IN & 16'h001F; end
      8'd6:    begin w_nbits_in = 5'd6;  w_data_act = DATA_IN & 16'h003F; end
      8'd7:    begin w_nbits_in = 5'd7;  w_data_act = DATA_IN & 16'h007F; end
      8'd16:   begin w_nbits_in = 5'd16; w_data_act = DATA_IN;             end
      default: begin w_nbits_in = 5'd8;  w_data_act = DATA_IN & 16'h00FF; end
    endcase
    w_par_en_in = (PARITY_BIT >= 8'd1) && (PARITY_BIT <= 8'd4);
    case (PARITY_BIT)
      8'd1:    w_par_in = ~(^w_data_act);  // odd: total ones including parity odd
      8'd2:    w_par_in = ^w_data_act;
      8'd3:    w_par_in = 1'b1;
      default: w_par_in = 1'b0;
    endcase
    w_stop_in = (STOP_BIT > 8'd2) ? 2'd0 : STOP_BIT[1:0];
  end

  // Next bit length: {carry,frac} = frac + corr, length = div + carry
  assign w_fsum    = {1'b0, r_frac} + {1'b0, r_corr};
  assign w_len_m1  = r_div - 24'd1 + {23'd0, w_fsum[2]};
  assign w_bit_end = (r_clkcnt == 24'd0);

  always_comb begin
    w_state_nxt   = r_state;
    w_txd_nxt     = r_txd;
    w_done_nxt    = 1'b0;
    w_frac_nxt    = r_frac;
    w_clkcnt_nxt  = w_bit_end ? 24'd0 : r_clkcnt - 24'd1;
    w_bitcnt_nxt  = r_bitcnt;
    w_shift_nxt   = r_shift;
    w_stopcnt_nxt = r_stopcnt;
    w_accept      = 1'b0;
    w_next_bit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_txd_nxt = 1'b1;
        if (DATA_SEND && !UART_CTS) begin
          // Start bit: frac starts at 0, so 0 + corr never carries here
          w_accept      = 1'b1;
          w_state_nxt   = S_START;
          w_txd_nxt     = 1'b0;
          w_clkcnt_nxt  = w_div_in - 24'd1;
          w_frac_nxt    = DIV_CORRECT;
          w_bitcnt_nxt  = 5'd0;
          w_shift_nxt   = DATA_IN;
          w_stopcnt_nxt = 1'b0;
        end
      end
      S_START: if (w_bit_end) begin
        w_state_nxt = S_DATA;
        w_txd_nxt   = r_shift[0];
        w_next_bit  = 1'b1;
      end
      S_DATA: if (w_bit_end) begin
        w_next_bit = 1'b1;
        if (r_bitcnt == r_nbits - 5'd1) begin
          w_bitcnt_nxt = 5'd0;
          w_state_nxt  = r_par_en ? S_PARITY : S_STOP;
          w_txd_nxt    = r_par_en ? r_par_val : 1'b1;
        end else begin
          w_bitcnt_nxt = r_bitcnt + 5'd1;
          w_shift_nxt  = r_shift >> 1;
          w_txd_nxt    = r_shift[1];
        end
      end
      S_PARITY: if (w_bit_end) begin
        w_state_nxt = S_STOP;
        w_txd_nxt   = 1'b1;
        w_next_bit  = 1'b1;
      end
      S_STOP: if (w_bit_end) begin
        if (r_stop_mode == 2'd2 && !r_stopcnt) begin
          w_stopcnt_nxt = 1'b1;
          w_next_bit    = 1'b1;
        end else if (r_stop_mode == 2'd1) begin
          // Half stop is a plain floor(div/2); it does not touch frac
          w_state_nxt  = S_HALF_STOP;
          w_clkcnt_nxt = (r_div >> 1) - 24'd1;
        end else begin
          w_state_nxt   = S_IDLE;
          w_done_nxt    = 1'b1;
          w_stopcnt_nxt = 1'b0;
        end
      end
      S_HALF_STOP: if (w_bit_end) begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_next_bit) begin
      w_clkcnt_nxt = w_len_m1;
      w_frac_nxt   = w_fsum[1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_state     <= S_IDLE;
      r_txd       <= 1'b1;
      r_done      <= 1'b0;
      r_frac      <= 2'd0;
      r_clkcnt    <= 24'd0;
      r_bitcnt    <= 5'd0;
      r_shift     <= 16'd0;
      r_stopcnt   <= 1'b0;
      r_div       <= 24'd0;
      r_corr      <= 2'd0;
      r_nbits     <= 5'd0;
      r_par_en    <= 1'b0;
      r_par_val   <= 1'b0;
      r_stop_mode <= 2'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_txd     <= w_txd_nxt;
      r_done    <= w_done_nxt;
      r_frac    <= w_frac_nxt;
      r_clkcnt  <= w_clkcnt_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_shift   <= w_shift_nxt;
      r_stopcnt <= w_stopcnt_nxt;
      if (w_accept) begin
        r_div       <= w_div_in;
        r_corr      <= DIV_CORRECT;
        r_nbits     <= w_nbits_in;
        r_par_en    <= w_par_en_in;
        r_par_val   <= w_par_in;
        r_stop_mode <= w_stop_in;
      end
    end
  end

  assign UART_TXD = r_txd;
  assign DONE     = r_done;
  assign BUSY     = (r_state != S_IDLE) || UART_CTS;

endmodule

// File: doc/uart_frame_tx.md
UART_FRAME_TX -- requirements
Module: uart_frame_tx

Interface
REQ-001 SHALL: CLK  input  1  system clock; all logic on rising edge.
REQ-002 SHALL: RSTN  input  1  reset, synchronous, active-low.
REQ-003 SHALL: DIVIDER_VALUE  input  24  integer clocks per bit.
REQ-004 SHALL: DIV_CORRECT  input  2  fractional quarter-clocks per bit.
REQ-005 SHALL: PARITY_BIT  input  8  0 none, 1 odd, 2 even, 3 mark, 4 space.
REQ-006 SHALL: STOP_BIT  input  8  0 one, 1 one-and-half, 2 two stop bits.
REQ-007 SHALL: DATA_BITS  input  8  5, 6, 7, 8 or 16 data bits.
REQ-008 SHALL: DATA_IN  input  16  word to send, LSB first.
REQ-009 SHALL: DATA_SEND  input  1  send request.
REQ-010 SHALL: UART_CTS  input  1  0 = far end ready to receive.
REQ-011 SHALL: UART_TXD  output  1  serial line, idle high, registered.
REQ-012 SHALL: BUSY  output  1  1 = request will not be accepted.
REQ-013 SHALL: DONE  output  1  one-cycle pulse at frame end.

Function
REQ-014 SHALL: states IDLE, START, DATA, PARITY, STOP, HALF_STOP.
REQ-015 SHALL: BUSY = (state != IDLE) OR UART_CTS; this is the only combinational output.
REQ-016 SHALL: accept when DATA_SEND=1 in IDLE with UART_CTS=0; DATA_SEND is ignored otherwise, with no queuing.
REQ-017 SHALL: on accept, latch DATA_IN, DIVIDER_VALUE, DIV_CORRECT, PARITY_BIT, STOP_BIT and DATA_BITS; input changes mid-frame have no effect.
REQ-018 SHALL: UART_TXD goes low the cycle after accept (start bit); UART_CTS is not checked again mid-frame.
REQ-019 SHALL: bit length: fractional accumulator frac[1:0] clears to 0 on accept; for each bit, {carry,frac} = frac + DIV_CORRECT and length = DIVIDER_VALUE + carry clocks.
REQ-020 SHALL: DIVIDER_VALUE < 2 is treated as 2.
REQ-021 SHALL: DATA shifts out the latched bits, LSB first, for the latched width; a DATA_BITS value outside {5,6,7,8,16} is treated as 8.
REQ-022 SHALL: PARITY state is entered only when PARITY_BIT is 1..4; the value is odd/even over the active data bits only, mark = 1, space = 0; PARITY_BIT > 4 = none.
REQ-023 SHALL: STOP drives 1 for one bit length (STOP_BIT=0), two bit lengths (2), or one bit length followed by HALF_STOP of floor(DIVIDER_VALUE/2) clocks (1); values > 2 are treated as 0.
REQ-024 SHALL: at the last stop clock, return to IDLE and pulse DONE for exactly one cycle, coincident with state becoming IDLE.
REQ-025 SHALL: a DATA_SEND on the first IDLE cycle after DONE is accepted (back-to-back, no gap beyond stop bits).
REQ-026 SHALL: the bit counter wraps only at the latched width; there is no extra bit on wrap.

Reset
REQ-027 SHALL: RSTN=0 at a clock edge forces, next cycle, state IDLE, UART_TXD=1, DONE=0, frac=0, shift register and counters 0.
REQ-028 SHALL: reset mid-frame aborts the frame immediately with no DONE pulse; BUSY then equals UART_CTS.

Verification
REQ-029 SHALL: DIVIDER=4, CORR=0, 8N1, DATA_IN=0x55 -> TXD sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 clocks; BUSY high 40 cycles; one DONE.
REQ-030 SHALL: DIVIDER=4, CORR=2, 8N1 -> bit lengths 4,5,4,5,... for a frame total of 45 cycles.
REQ-031 SHALL: 7 data bits, odd parity, DATA_IN=0x03 -> parity bit 1; even parity -> 0; mark -> 1; space -> 0.
REQ-032 SHALL: DIVIDER=8, STOP_BIT=1 -> stop high for 12 cycles; STOP_BIT=2 -> 16 cycles; 16-bit word 0xA5C3 sent LSB first.
REQ-033 SHALL: UART_CTS=1 with DATA_SEND=1 -> no start bit and BUSY=1; CTS raised mid-frame -> frame completes.
REQ-034 SHALL: RSTN low during the DATA state -> next cycle TXD=1, no DONE, with no accept while RSTN=0; a subsequent request sends a correct full frame.
